// File: rtl/caesar_stream_ctrl.sv
// Streaming Caesar cipher sequencer: configure key/direction, then shift a
// msg_len-byte message from a valid/ready input stream to a valid/ready output stream.
module caesar_stream_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [4:0]       cfg_key,
    input  logic             cfg_en,
    input  logic             cfg_prog,
    output logic             cfg_ready,
    input  logic             start,
    input  logic [CNT_W-1:0] msg_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] char_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       key_q, key_d;
    logic [4:0]       cur_key_q, cur_key_d;
    logic             en_q, en_d;
    logic             prog_q, prog_d;
    logic [CNT_W-1:0] char_cnt_q, char_cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             in_hs;
    logic             out_hs;

    function automatic logic [4:0] reduce_key(input logic [4:0] k);
        return (k >= 5'd26) ? k - 5'd26 : k;
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7a)) || ((b >= 8'h41) && (b <= 8'h5a));
    endfunction

    // Decrypt adds the complement (26-k) so both directions share one 6-bit adder
    // followed by a single conditional subtract.
    function automatic logic [7:0] shift_byte(input logic [7:0] b, input logic [4:0] k,
                                              input logic enc);
        logic [7:0] base;
        logic [7:0] diff;
        logic [5:0] sum;
        base = ((b >= 8'h61) && (b <= 8'h7a)) ? 8'd97 : 8'd65;
        diff = b - base;
        if (enc) begin
            sum = {1'b0, diff[4:0]} + {1'b0, k};
        end else begin
            sum = {1'b0, diff[4:0]} + {1'b0, 5'd26 - k};
        end
        if (sum >= 6'd26) begin
            sum = sum - 6'd26;
        end
        return is_letter(b) ? base + {3'b000, sum[4:0]} : b;
    endfunction

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign char_cnt  = char_cnt_q;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        cur_key_d   = cur_key_q;
        en_d        = en_q;
        prog_d      = prog_q;
        char_cnt_d  = char_cnt_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        key_d  = reduce_key(cfg_key);
                        en_d   = cfg_en;
                        prog_d = cfg_prog;
                    end
                    if (start) begin
                        cur_key_d  = cfg_valid ? reduce_key(cfg_key) : key_q;
                        char_cnt_d = '0;
                        rem_d      = msg_len;
                        state_d    = (msg_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        out_valid_d = 1'b1;
                        out_data_d  = shift_byte(in_data, cur_key_q, en_q);
                        rem_d       = rem_q - CNT_W'(1);
                        char_cnt_d  = char_cnt_q + CNT_W'(1);
                        if (prog_q && is_letter(in_data)) begin
                            cur_key_d = (cur_key_q == 5'd25) ? 5'd0 : cur_key_q + 5'd1;
                        end
                        if (rem_q == CNT_W'(1)) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= 5'd0;
            cur_key_q   <= 5'd0;
            en_q        <= 1'b1;
            prog_q      <= 1'b0;
            char_cnt_q  <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            cur_key_q   <= cur_key_d;
            en_q        <= en_d;
            prog_q      <= prog_d;
            char_cnt_q  <= char_cnt_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_caesar_stream_ctrl.sv
// Directed bench for caesar_stream_ctrl: expected bytes are queued as inputs are
// accepted and compared by a monitor as each output handshake happens.
module tb_caesar_stream_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic [4:0]       cfg_key;
    logic             cfg_en;
    logic             cfg_prog;
    logic             cfg_ready;
    logic             start;
    logic [CNT_W-1:0] msg_len;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] char_cnt;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    caesar_stream_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_key   (cfg_key),
        .cfg_en    (cfg_en),
        .cfg_prog  (cfg_prog),
        .cfg_ready (cfg_ready),
        .start     (start),
        .msg_len   (msg_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .char_cnt  (char_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_output", out_data, 32'hffff_ffff);
            end else begin
                check_output("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic start_msg(input bit with_cfg, input logic [4:0] key, input logic enc,
                             input logic prog, input logic [CNT_W-1:0] len);
        @(posedge clk); #1;
        cfg_valid = with_cfg;
        cfg_key   = key;
        cfg_en    = enc;
        cfg_prog  = prog;
        start     = 1'b1;
        msg_len   = len;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp, output int waited);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check_output("in_ready_wait", in_ready, 1);
        if (in_ready) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_string(input string din, input string dexp, output int total_wait);
        int w;
        total_wait = 0;
        for (int i = 0; i < din.len(); i++) begin
            send_byte(din[i], dexp[i], w);
            total_wait += w;
        end
    endtask

    task automatic expect_done(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check_output({tag, "_done_lat"}, n, exp_lat);
        @(negedge clk);
        check_output({tag, "_done_pulse"}, done, 0);
        check_output({tag, "_idle"}, cfg_ready, 1);
        check_output({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int w;
        int seen;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_key = 5'd0; cfg_en = 1'b0; cfg_prog = 1'b0;
        start = 1'b0; msg_len = '0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b1;
        #12;
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_data", out_data, 0);
        check_output("rst_in_ready", in_ready, 0);
        check_output("rst_cfg_ready", cfg_ready, 1);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_char_cnt", char_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero-length message
        start_msg(1'b0, 5'd0, 1'b1, 1'b0, 16'd0);
        @(negedge clk);
        check_output("len0_done", done, 1);
        check_output("len0_in_ready", in_ready, 0);
        @(negedge clk);
        check_output("len0_done_pulse", done, 0);
        check_output("len0_in_ready_after", in_ready, 0);

        // Reset configuration is key 0 encrypt
        start_msg(1'b0, 5'd0, 1'b0, 1'b0, 16'd1);
        send_string("m", "m", w);
        expect_done("rstcfg", 2);

        start_msg(1'b1, 5'd3, 1'b1, 1'b0, 16'd3);
        send_string("abz", "dec", w);
        check_output("abz_back_to_back", w, 0);
        expect_done("abz", 2);
        check_output("abz_char_cnt", char_cnt, 3);

        start_msg(1'b1, 5'd3, 1'b0, 1'b0, 16'd4);
        send_string("DEC!", "ABZ!", w);
        expect_done("dec", 2);

        start_msg(1'b1, 5'd25, 1'b1, 1'b1, 16'd4);
        send_string("a ab", "z ac", w);
        expect_done("prog_enc", 2);

        start_msg(1'b1, 5'd25, 1'b0, 1'b1, 16'd4);
        send_string("z ac", "a ab", w);
        expect_done("prog_dec", 2);

        start_msg(1'b1, 5'd29, 1'b1, 1'b0, 16'd2);
        send_string("aX", "dA", w);
        expect_done("key29", 2);

        // Backpressure: stall the sink for three cycles with 'c' waiting at the input
        start_msg(1'b1, 5'd2, 1'b1, 1'b0, 16'd5);
        send_string("ab", "cd", w);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = "c";
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("bp_in_ready", in_ready, 0);
            check_output("bp_out_valid", out_valid, 1);
            check_output("bp_out_data", out_data, 8'h64);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_string("cde", "efg", w);
        expect_done("bp", 2);
        check_output("bp_char_cnt", char_cnt, 5);

        // Abort with a byte pending at the output
        start_msg(1'b1, 5'd3, 1'b1, 1'b0, 16'd5);
        send_string("he", "kh", w);
        check_output("abort_char_cnt", char_cnt, 2);
        out_ready = 1'b0;
        abort     = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_output("abort_out_valid", out_valid, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_cfg_ready", cfg_ready, 1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_output("abort_no_done", seen, 0);
        start_msg(1'b1, 5'd1, 1'b1, 1'b0, 16'd1);
        send_string("y", "z", w);
        expect_done("post_abort", 2);

        // Asynchronous reset mid-message
        start_msg(1'b1, 5'd5, 1'b1, 1'b0, 16'd3);
        out_ready = 1'b0;
        send_string("a", "f", w);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_char_cnt", char_cnt, 0);
        check_output("midrst_out_data", out_data, 0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("midrst_cfg_ready", cfg_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/caesar_stream_ctrl.md
# caesar_stream_ctrl

Streaming sequencer for the Caesar cipher letter datapath. Accepts a configured key and direction, then processes a message of `msg_len` ASCII bytes over a valid/ready input stream. Each letter is shifted modulo 26 with its case preserved; non-letters pass through unchanged. Results leave on a valid/ready output stream, so a byte-serial source (UART, FIFO) can drive the cipher without one-hot decoding.

## Interface
- `CNT_W`, default 16: width of message length and character counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_valid` in 1: load configuration; honoured only in IDLE.
- `cfg_key` in 5: shift amount. Values 26..31 are reduced by 26.
- `cfg_en` in 1: 1 = encrypt (add key), 0 = decrypt (subtract key).
- `cfg_prog` in 1: progressive mode; key advances by 1 mod 26 after each letter.
- `cfg_ready` out 1: high exactly when state is IDLE.
- `start` in 1: begin message; honoured only in IDLE.
- `msg_len` in CNT_W: byte count, sampled on `start`.
- `abort` in 1: synchronous abort from any state.
- `in_valid` / `in_ready` in / out 1: input handshake.
- `in_data` in 8: input ASCII byte.
- `out_valid` / `out_ready` out / in 1: output handshake.
- `out_data` out 8: output ASCII byte.
- `busy` out 1: state is not IDLE.
- `done` out 1: single-cycle pulse when a message completes.
- `char_cnt` out CNT_W: bytes accepted in the current message.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, on `cfg_valid`: latch key (reduced mod 26), direction and progressive bit. If `cfg_valid` and `start` arrive together, the new configuration applies to that message.
- IDLE, on `start`:
  - Load `cur_key` from the configured key.
  - Clear `char_cnt`; load remaining count from `msg_len`.
  - `msg_len`=0: go to DONE directly.
  - Otherwise go to RUN.
- RUN:
  - `in_ready` = !`out_valid` | `out_ready`.
  - On each input handshake, decrement the remaining count, increment `char_cnt` and register the transformed byte into `out_data`.
  - Accepting the last byte moves to DRAIN.
- DRAIN: hold until the output handshake of the final byte, then go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- Transform:
  - 'a'..'z' uses base 97; 'A'..'Z' uses base 65; the case of the output matches the input.
  - idx = byte − base.
  - Encrypt: (idx + k) mod 26. Decrypt: (idx + 26 − k) mod 26.
  - Output = base + result.
  - All other byte values pass through unchanged and never advance the key.
- Progressive mode: after each letter is accepted, `cur_key` = (`cur_key`+1) mod 26, with 25 wrapping to 0. Encrypt and decrypt use the same schedule, so decrypt inverts encrypt.
- Arithmetic: index and key are 5-bit. The sum is formed in 6 bits, with a single conditional subtract of 26.
- Abort: next state is IDLE and `out_valid` clears, even if a byte is pending. `done` is not pulsed and the configuration is retained.
- `start` and `cfg_valid` outside IDLE are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`=0, `out_data`=0, `in_ready`=0, `cfg_ready`=1.
  - `busy`=0, `done`=0, `char_cnt`=0.
  - Key 0, `cfg_en`=1, `cfg_prog`=0.
- `start` sampled at edge N: `in_ready` may be high from cycle N+1.
- Latency: input handshake at edge N gives `out_valid` with data from N+1.
- Throughput: 1 byte per cycle while `out_ready`=1.
- Backpressure: while `out_valid` & !`out_ready`:
  - `in_ready`=0.
  - `out_data` and `out_valid` hold stable.
- `done` is high the cycle after the final output handshake.
- With `msg_len`=0, `done` is high the cycle after `start`.
- `in_ready` depends combinationally on `out_ready` only; there is no path from `in_valid` to `in_ready`.
- `rst_n` low mid-message clears everything immediately. Any partial output is discarded.

## Test plan
- Reset -> all outputs at the reset values above.
  - Then start with `msg_len`=0 -> `done` pulses 1 cycle, with no `in_ready`.
- Encrypt, key 3, input "abz" with `out_ready`=1:
  - Output "dec", back-to-back.
  - `char_cnt`=3.
  - `done` one cycle after the 'c' handshake.
- Decrypt, key 3, input "DEC!" -> output "ABZ!".
  - Confirms uppercase is preserved and '!' passes through.
- Progressive encrypt, key 25, input "a ab" -> output "z ac".
  - The space does not advance the key.
  - Progressive decrypt, key 25, of "z ac" returns "a ab".
- Backpressure: drop `out_ready` for 3 cycles mid-message.
  - `in_ready`=0 and `out_data` stays stable for those cycles.
  - No byte is lost or duplicated.
- Abort after 2 of 5 bytes:
  - `out_valid` clears, state goes to IDLE, no `done`.
  - A new start with key 1 on "y" -> output "z".
